// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and defaults for the inter-stage pipeline register.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  localparam int PAYLOAD_W  = 160;
  localparam int PERF_CNT_W = 16;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready payload stream between two pipeline stages.
interface pipe_stage_skid_if
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W = PAYLOAD_W
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter used for the stall/bubble performance monitors.
module pipe_stage_skid_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with optional 2-entry skid buffer, flush-to-NOP
// and saturating stall/bubble counters.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int                DATA_W      = PAYLOAD_W,
  parameter int                SKID        = 1,
  parameter logic [DATA_W-1:0] NOP_PAYLOAD = '0,
  parameter int                CNT_W       = PERF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  pipe_stage_skid_if.slave       up,
  pipe_stage_skid_if.master      dn,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       bubble_cnt
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic              dn_valid;
  logic              up_fire;
  logic              dn_fire;

  assign dn_valid = (state_q != EMPTY);
  assign up_fire  = up.valid && up.ready;
  assign dn_fire  = dn_valid && dn.ready;

  // Bubble encoding: nothing stale ever leaves the stage.
  assign dn.valid = dn_valid;
  assign dn.data  = dn_valid ? m_q : NOP_PAYLOAD;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // NOTE: payload registers carry no reset; dn_valid qualifies them and dn.data is masked.
  always_ff @(posedge clk) m_q <= m_d;

  if (SKID != 0) begin : g_skid
    logic [DATA_W-1:0] s_q, s_d;
    logic              up_ready_q;

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
      state_d = state_q;
      m_d     = m_q;
      s_d     = s_q;
      unique case (state_q)
        EMPTY: begin
          if (up_fire) begin
            m_d     = up.data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (up_fire && dn_fire) begin
            m_d = up.data;
          end else if (up_fire) begin
            s_d     = up.data;
            state_d = TWO;
          end else if (dn_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // up_ready is low here, so the only event is the older entry draining.
          if (dn_fire) begin
            m_d     = s_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
      if (flush) state_d = EMPTY;
    end

    always_ff @(posedge clk) s_q <= s_d;

    // Registered ready: computed from next state so it is exact, yet has no path from dn.ready.
    always_ff @(posedge clk) begin
      if (rst) up_ready_q <= 1'b1;
      else     up_ready_q <= (state_d != TWO);
    end

    assign up.ready = up_ready_q;
  end else begin : g_single
    assign up.ready = !dn_valid || dn.ready;

    always_comb begin
      state_d = state_q;
      m_d     = m_q;
      if (up_fire) begin
        m_d     = up.data;
        state_d = ONE;
      end else if (dn_fire) begin
        state_d = EMPTY;
      end
      if (flush) state_d = EMPTY;
    end
  end

  // Counters observe pre-flush dn_valid, so a flushed stall cycle still counts.
  pipe_stage_skid_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (dn_valid && !dn.ready),
    .cnt (stall_cnt)
  );

  pipe_stage_skid_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (!dn_valid && dn.ready),
    .cnt (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: SKID=1 (16-bit and 4-bit counters) and SKID=0 instances.
module tb_pipe_stage_skid;

  localparam int DW  = 16;
  localparam int NOP = 'hF00F;
  localparam int NV  = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_skid_if #(.DATA_W(DW)) a_up ();
  pipe_stage_skid_if #(.DATA_W(DW)) a_dn ();
  pipe_stage_skid_if #(.DATA_W(DW)) b_up ();
  pipe_stage_skid_if #(.DATA_W(DW)) b_dn ();
  pipe_stage_skid_if #(.DATA_W(DW)) c_up ();
  pipe_stage_skid_if #(.DATA_W(DW)) c_dn ();

  logic [15:0] a_stall, a_bubble, c_stall, c_bubble;
  logic [3:0]  b_stall, b_bubble;

  pipe_stage_skid #(.DATA_W(DW), .SKID(1), .NOP_PAYLOAD(16'(NOP)), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .up(a_up), .dn(a_dn),
    .stall_cnt(a_stall), .bubble_cnt(a_bubble));

  pipe_stage_skid #(.DATA_W(DW), .SKID(1), .NOP_PAYLOAD(16'(NOP)), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .flush(1'b0), .up(b_up), .dn(b_dn),
    .stall_cnt(b_stall), .bubble_cnt(b_bubble));

  pipe_stage_skid #(.DATA_W(DW), .SKID(0), .NOP_PAYLOAD(16'(NOP)), .CNT_W(16)) u_c (
    .clk(clk), .rst(rst), .flush(1'b0), .up(c_up), .dn(c_dn),
    .stall_cnt(c_stall), .bubble_cnt(c_bubble));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        flush;
    logic        up_valid;
    logic [15:0] up_data;
    logic        dn_ready;
    logic        exp_dn_valid;
    logic [15:0] exp_dn_data;
    logic        exp_up_ready;
    int          exp_stall;
    int          exp_bubble;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input int fl, input int v, input int d, input int r,
                              input int edv, input int edata, input int eur,
                              input int es, input int eb);
    vec_t t;
    t.flush        = fl[0];
    t.up_valid     = v[0];
    t.up_data      = 16'(d);
    t.dn_ready     = r[0];
    t.exp_dn_valid = edv[0];
    t.exp_dn_data  = 16'(edata);
    t.exp_up_ready = eur[0];
    t.exp_stall    = es;
    t.exp_bubble   = eb;
    return t;
  endfunction

  logic [15:0] q [$];
  int          sent;
  int          rcvd;
  logic        exp_ur;

  initial begin
    // Streaming with 1-cycle lag, skid fill/drain, then flush in TWO and in ONE.
    //              fl v  data   r    dv data   ur  stall bubble
    vecs[0]  = mk(0, 1, 'h01,  1,   0, NOP,   1,  0, 0);
    vecs[1]  = mk(0, 1, 'h02,  1,   1, 'h01,  1,  0, 1);
    vecs[2]  = mk(0, 1, 'h03,  1,   1, 'h02,  1,  0, 1);
    vecs[3]  = mk(0, 1, 'h04,  1,   1, 'h03,  1,  0, 1);
    vecs[4]  = mk(0, 1, 'h05,  1,   1, 'h04,  1,  0, 1);
    vecs[5]  = mk(0, 0, 'h00,  1,   1, 'h05,  1,  0, 1);
    vecs[6]  = mk(0, 0, 'h00,  1,   0, NOP,   1,  0, 1);
    vecs[7]  = mk(0, 1, 'h0A,  1,   0, NOP,   1,  0, 2);
    vecs[8]  = mk(0, 1, 'h0B,  0,   1, 'h0A,  1,  0, 3);
    vecs[9]  = mk(0, 1, 'h0C,  0,   1, 'h0A,  0,  1, 3);
    vecs[10] = mk(0, 1, 'h0C,  0,   1, 'h0A,  0,  2, 3);
    vecs[11] = mk(0, 1, 'h0C,  1,   1, 'h0A,  0,  3, 3);
    vecs[12] = mk(0, 1, 'h0C,  1,   1, 'h0B,  1,  3, 3);
    vecs[13] = mk(0, 0, 'h00,  1,   1, 'h0C,  1,  3, 3);
    vecs[14] = mk(0, 0, 'h00,  0,   0, NOP,   1,  3, 3);
    vecs[15] = mk(0, 1, 'h11,  0,   0, NOP,   1,  3, 3);
    vecs[16] = mk(0, 1, 'h22,  0,   1, 'h11,  1,  3, 3);
    vecs[17] = mk(1, 1, 'h33,  0,   1, 'h11,  0,  4, 3);
    vecs[18] = mk(0, 0, 'h00,  1,   0, NOP,   1,  5, 3);
    vecs[19] = mk(0, 0, 'h00,  1,   0, NOP,   1,  5, 4);
    vecs[20] = mk(0, 1, 'h44,  1,   0, NOP,   1,  5, 5);
    vecs[21] = mk(1, 1, 'h55,  0,   1, 'h44,  1,  5, 6);
    vecs[22] = mk(0, 0, 'h00,  1,   0, NOP,   1,  6, 6);
    vecs[23] = mk(0, 0, 'h00,  0,   0, NOP,   1,  6, 7);

    a_up.valid = 1'b0; a_up.data = '0; a_dn.ready = 1'b0;
    b_up.valid = 1'b0; b_up.data = '0; b_dn.ready = 1'b0;
    c_up.valid = 1'b0; c_up.data = '0; c_dn.ready = 1'b0;

    // Reset state.
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    #2;
    check("rst a_dn_valid", 32'(a_dn.valid), 32'(0));
    check("rst a_dn_data", 32'(a_dn.data), 32'(NOP));
    check("rst a_up_ready", 32'(a_up.ready), 32'(1));
    check("rst a_stall", 32'(a_stall), 32'(0));
    check("rst a_bubble", 32'(a_bubble), 32'(0));
    check("rst b_up_ready", 32'(b_up.ready), 32'(1));
    check("rst c_up_ready", 32'(c_up.ready), 32'(1));

    for (int k = 0; k < NV; k++) begin
      flush      = vecs[k].flush;
      a_up.valid = vecs[k].up_valid;
      a_up.data  = vecs[k].up_data;
      a_dn.ready = vecs[k].dn_ready;
      #2;
      check($sformatf("row%0d dn_valid", k), 32'(a_dn.valid), 32'(vecs[k].exp_dn_valid));
      check($sformatf("row%0d dn_data", k), 32'(a_dn.data), 32'(vecs[k].exp_dn_data));
      check($sformatf("row%0d up_ready", k), 32'(a_up.ready), 32'(vecs[k].exp_up_ready));
      check($sformatf("row%0d stall_cnt", k), 32'(a_stall), 32'(vecs[k].exp_stall));
      check($sformatf("row%0d bubble_cnt", k), 32'(a_bubble), 32'(vecs[k].exp_bubble));
      tick;
    end
    flush = 1'b0;

    // Reset while holding two entries.
    a_up.valid = 1'b1; a_up.data = 16'h0066; a_dn.ready = 1'b0;
    tick;
    a_up.data = 16'h0077;
    tick;
    #1;
    check("two a_dn_valid", 32'(a_dn.valid), 32'(1));
    check("two a_dn_data", 32'(a_dn.data), 32'h66);
    check("two a_up_ready", 32'(a_up.ready), 32'(0));
    check("two a_stall", 32'(a_stall), 32'(7));
    rst = 1'b1; a_up.data = 16'h0088; a_dn.ready = 1'b1;
    tick;
    rst = 1'b0; a_up.valid = 1'b0;
    #1;
    check("midrst a_dn_valid", 32'(a_dn.valid), 32'(0));
    check("midrst a_dn_data", 32'(a_dn.data), 32'(NOP));
    check("midrst a_up_ready", 32'(a_up.ready), 32'(1));
    check("midrst a_stall", 32'(a_stall), 32'(0));
    check("midrst a_bubble", 32'(a_bubble), 32'(0));
    tick;
    #1;
    check("postrst a_dn_valid", 32'(a_dn.valid), 32'(0));
    check("postrst a_bubble", 32'(a_bubble), 32'(1));
    a_dn.ready = 1'b0;

    // 4-bit stall counter saturation.
    b_up.valid = 1'b1; b_up.data = 16'h005A; b_dn.ready = 1'b0;
    tick;
    b_up.valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick;
      #1;
      check($sformatf("sat k%0d b_stall", k), 32'(b_stall), 32'((k > 15) ? 15 : k));
    end
    check("sat b_dn_valid", 32'(b_dn.valid), 32'(1));
    check("sat b_dn_data", 32'(b_dn.data), 32'h5A);
    check("sat b_bubble", 32'(b_bubble), 32'(0));

    // SKID=0 with toggling dn_ready: scoreboard ordering and combinational ready.
    sent = 0;
    rcvd = 0;
    q.delete();
    for (int i = 0; i < 200 && rcvd < 50; i++) begin
      c_dn.ready = (i % 2 == 0);
      c_up.valid = (sent < 50);
      c_up.data  = 16'($urandom);
      #2;
      exp_ur = (q.size() == 0) || c_dn.ready;
      check($sformatf("c%0d up_ready", i), 32'(c_up.ready), 32'(exp_ur));
      check($sformatf("c%0d dn_valid", i), 32'(c_dn.valid), 32'(q.size() != 0));
      check($sformatf("c%0d dn_data", i), 32'(c_dn.data),
            32'((q.size() != 0) ? q[0] : 16'(NOP)));
      if ((q.size() != 0) && c_dn.ready) begin
        void'(q.pop_front());
        rcvd++;
      end
      if (c_up.valid && exp_ur) begin
        q.push_back(c_up.data);
        sent++;
      end
      tick;
    end
    check("c received", 32'(rcvd), 32'(50));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
